// File: rtl/mem_slot_sched.sv
// Time-slot scheduler for the shared 22-bit physical memory bus.
// Each mck cycle is granted to the Z80 (its own slot, the last phase of a
// Z80 clock) or to the LCD fetch engine. All bus strobes come straight
// from registers, and read data is captured for whichever side owned the cycle.
module mem_slot_sched #(
  parameter int NPH       = 3,
  parameter bit VID_STEAL = 1'b1
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic [21:0] za,
  input  logic        mrq_n,
  input  logic        crd_n,
  input  logic        clk_stop,
  input  logic        vid_req,
  input  logic [21:0] vid_addr,
  input  logic [7:0]  cdi,
  output logic        vid_ack,
  output logic        vid_rdy,
  output logic [7:0]  vid_data,
  output logic [7:0]  z80_dat,
  output logic        z80_clk,
  output logic [1:0]  phase,
  output logic [21:0] ma,
  output logic        ipce_n,
  output logic        irce_n,
  output logic        se1_n,
  output logic        se2_n,
  output logic        se3_n,
  output logic        roe_n,
  output logic        wrb_n
);

  localparam logic [1:0] LAST_PH = 2'(NPH - 1);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_Z80  = 2'd1,
    GNT_VID  = 2'd2
  } gnt_t;

  gnt_t        gnt_reg;
  gnt_t        gnt_next;
  logic [1:0]  phase_next;
  logic        slot_next;
  logic [21:0] ma_next;
  logic [3:1]  se_hit;
  logic [4:0]  ce_next;   // {ipce, irce, se1, se2, se3}, active-low
  logic        roe_next;
  logic        wrb_next;

  // Phase advance: wrap at the Z80 slot; a stop request lets the counter
  // run on until it reaches 0 and then parks it there.
  always_comb begin
    phase_next = phase + 2'd1;
    if (clk_stop && phase == 2'd0) begin
      phase_next = 2'd0;
    end else if (phase == LAST_PH) begin
      phase_next = 2'd0;
    end
  end

  // Arbitration for the upcoming cycle: the Z80 always owns its slot; video
  // takes any other cycle, the idle Z80 slot when stealing is enabled, and
  // every cycle while the Z80 clock is stopped. A cycle already acked blocks
  // a re-grant so each request is served once.
  always_comb begin
    slot_next = (phase_next == LAST_PH);
    gnt_next  = GNT_NONE;
    if (slot_next && !clk_stop && !mrq_n) begin
      gnt_next = GNT_Z80;
    end else if (vid_req && !vid_ack && (!slot_next || VID_STEAL || clk_stop)) begin
      gnt_next = GNT_VID;
    end
  end

  // Address mux: an idle cycle keeps the previous address on the bus.
  always_comb begin
    case (gnt_next)
      GNT_Z80: ma_next = za;
      GNT_VID: ma_next = vid_addr;
      default: ma_next = ma;
    endcase
  end

  // Slot-card window hits, one per external slot (ma[21:20] = 1..3).
  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_slot_hit
      assign se_hit[gi] = (ma_next[21:20] == 2'(gi));
    end
  endgenerate

  // Chip-enable and strobe decode for the upcoming cycle; only an owned
  // cycle may pull a strobe low, and video cycles are always reads.
  always_comb begin
    ce_next  = 5'b11111;
    roe_next = 1'b1;
    wrb_next = 1'b1;
    if (gnt_next != GNT_NONE) begin
      if (ma_next[21:20] == 2'b00) begin
        if (ma_next[19]) begin
          ce_next[3] = 1'b0;
        end else begin
          ce_next[4] = 1'b0;
        end
      end
      ce_next[2] = ~se_hit[1];
      ce_next[1] = ~se_hit[2];
      ce_next[0] = ~se_hit[3];
    end
    if (gnt_next == GNT_Z80) begin
      roe_next = crd_n;
      wrb_next = ~crd_n;
    end else if (gnt_next == GNT_VID) begin
      roe_next = 1'b0;
    end
  end

  // State and registered bus outputs; data is captured at the end of the
  // owned cycle, so a reset edge drops any access in flight.
  always_ff @(posedge mck) begin
    if (!rin_n) begin
      phase    <= 2'd0;
      gnt_reg  <= GNT_NONE;
      ma       <= 22'd0;
      {ipce_n, irce_n, se1_n, se2_n, se3_n} <= 5'b11111;
      roe_n    <= 1'b1;
      wrb_n    <= 1'b1;
      vid_ack  <= 1'b0;
      vid_rdy  <= 1'b0;
      z80_clk  <= 1'b0;
      vid_data <= 8'd0;
      z80_dat  <= 8'd0;
    end else begin
      phase    <= phase_next;
      gnt_reg  <= gnt_next;
      ma       <= ma_next;
      {ipce_n, irce_n, se1_n, se2_n, se3_n} <= ce_next;
      roe_n    <= roe_next;
      wrb_n    <= wrb_next;
      vid_ack  <= (gnt_next == GNT_VID);
      z80_clk  <= slot_next && !clk_stop;
      vid_rdy  <= (gnt_reg == GNT_VID);
      if (gnt_reg == GNT_VID) begin
        vid_data <= cdi;
      end
      if (gnt_reg == GNT_Z80 && !roe_n) begin
        z80_dat <= cdi;
      end
    end
  end

endmodule
